// File: rtl/booth_radix4_seq_mul.sv
// Sequential radix-4 Booth multiplier: one Booth digit retired per clock, WIDTH/2+1 digits.
// Operands are extended to WIDTH+2 bits so signed and unsigned share one datapath.
module booth_radix4_seq_mul #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int EW   = WIDTH + 2;
  localparam int AW   = WIDTH + 4;
  localparam int NDIG = WIDTH / 2 + 1;
  localparam int CW   = $clog2(NDIG + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, state_nxt;
  logic                 load;
  logic signed [EW-1:0] a_q;
  logic signed [AW-1:0] hi_q;
  logic [EW-1:0]        lo_q;
  logic                 bm1_q;
  logic [CW-1:0]        cnt_q;

  logic signed [AW-1:0] pp;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] hi_nxt;
  logic [EW-1:0]        lo_nxt;
  logic signed [EW-1:0] a_ext;
  logic [EW-1:0]        b_ext;

  function automatic logic signed [AW-1:0] booth_pp(input logic [2:0] win,
                                                    input logic signed [EW-1:0] a);
    logic signed [AW-1:0] a1;
    a1 = {{2{a[EW-1]}}, a};
    case (win)
      3'b001, 3'b010: booth_pp = a1;
      3'b011:         booth_pp = a1 <<< 1;
      3'b100:         booth_pp = -(a1 <<< 1);
      3'b101, 3'b110: booth_pp = -a1;
      default:        booth_pp = '0;
    endcase
  endfunction

  assign a_ext = signed_mode ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                             : {2'b00, multiplicand};
  assign b_ext = signed_mode ? {{2{multiplier[WIDTH-1]}}, multiplier}
                             : {2'b00, multiplier};

  // Booth step: add the selected partial product, then shift {hi, lo} right by 2
  assign pp     = booth_pp({lo_q[1:0], bm1_q}, a_q);
  assign sum    = hi_q + pp;
  assign hi_nxt = sum >>> 2;
  assign lo_nxt = {sum[1:0], lo_q[EW-1:2]};

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      CALC: begin
        if (cnt_q == CW'(1)) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      bm1_q   <= 1'b0;
      cnt_q   <= '0;
      product <= '0;
    end else if (load) begin
      a_q   <= a_ext;
      hi_q  <= '0;
      lo_q  <= b_ext;
      bm1_q <= 1'b0;
      cnt_q <= CW'(NDIG);
    end else if (state == CALC) begin
      hi_q  <= hi_nxt;
      lo_q  <= lo_nxt;
      bm1_q <= lo_q[1];
      cnt_q <= cnt_q - CW'(1);
      // After the last digit, {hi, lo} is the exact product
      if (cnt_q == CW'(1)) product <= {hi_nxt[2*WIDTH-EW-1:0], lo_nxt};
    end
  end

endmodule

// File: doc/booth_radix4_seq_mul.md
BOOTH_RADIX4_SEQ_MUL -- requirements
Module: booth_radix4_seq_mul

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; even, >= 4.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request a multiply; sampled on clk rising edge.
REQ-005 SHALL have port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned operands; sampled with start.
REQ-006 SHALL have port multiplicand  input  WIDTH  operand A; sampled with start.
REQ-007 SHALL have port multiplier  input  WIDTH  operand B; sampled with start.
REQ-008 SHALL have port busy  output  1  high while iterations run.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking product valid.
REQ-010 SHALL have port product  output  2*WIDTH  registered result.

Function
REQ-011 SHALL implement FSM states IDLE, CALC and DONE.
REQ-012 In IDLE or DONE with start=1, the block SHALL latch the operands and signed_mode, clear the accumulator, load the iteration counter with WIDTH/2+1, and enter CALC.
REQ-013 Operand latching SHALL extend both operands to WIDTH+2 bits: sign-extend when signed_mode=1, zero-extend when signed_mode=0.
REQ-014 Each CALC cycle SHALL retire one radix-4 Booth digit taken from the 3-bit multiplier window {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0.
REQ-015 Digit decode SHALL be: 000/111 -> 0; 001/010 -> +A; 011 -> +2A; 100 -> -2A; 101/110 -> -A.
REQ-016 The selected partial product SHALL be added to the accumulator, and the accumulator and multiplier window SHALL then shift arithmetically right by 2; no intermediate overflow is allowed.
REQ-017 CALC SHALL last exactly WIDTH/2+1 cycles, then transition to DONE.
REQ-018 On entry to DONE, product SHALL load the low 2*WIDTH bits of the exact product, signed or unsigned per the latched mode.
REQ-019 done SHALL be 1 only in DONE, for exactly one cycle, then the FSM SHALL return to IDLE unless start=1 (REQ-012).
REQ-020 busy SHALL be 1 exactly when the state is CALC.
REQ-021 Latency: with start sampled at edge 1, done SHALL be high after edge WIDTH/2+2 (18 for WIDTH=32).
REQ-022 start while busy=1 SHALL be ignored; operand or mode changes during CALC SHALL NOT affect the result.
REQ-023 start sampled in DONE SHALL begin a new operation with no idle cycle; product SHALL keep the old value until the new DONE.
REQ-024 product SHALL hold its value from DONE until the next DONE.
REQ-025 Boundary operands SHALL produce exact results: zero, all-ones, signed minimum (both operands minimum -> +2^(2*WIDTH-2)), and unsigned maximum.

Reset
REQ-026 When reset=0, the block SHALL asynchronously force state IDLE, busy=0, done=0, product=0, and clear the accumulator, counter and latched operands.
REQ-027 Reset asserted mid-CALC SHALL abort the operation; no done pulse for it SHALL follow deassertion.
REQ-028 After reset deasserts, the first start SHALL be accepted on the next rising edge.

Verification
REQ-029 WIDTH=32, signed, A=-3, B=7 -> done after 18 edges, product=0xFFFFFFFFFFFFFFEB.
REQ-030 WIDTH=32, unsigned, A=B=0xFFFFFFFF -> product=0xFFFFFFFE00000001; the same operands with signed_mode=1 -> product=0x0000000000000001.
REQ-031 WIDTH=32, signed, A=B=0x80000000 -> product=0x4000000000000000.
REQ-032 Start with A=5, B=6, then pulse start with A=9, B=9 during CALC -> single done, product=30, busy high for exactly 17 cycles.
REQ-033 Back-to-back: start held high across DONE with a second operand pair -> second done at edge 36, first product stable until then.
REQ-034 Reset pulsed at CALC cycle 5 -> product=0, busy=0, no done; WIDTH=8 exhaustive signed and unsigned sweep matches the reference model.
